// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl
// Sequencing controller for a lane-serial Keccak core. It absorbs rate lanes
// one beat per cycle and runs NUM_ROUNDS permutation rounds, one per cycle,
// while presenting the iota round constant. After the final block it streams
// OUT_LANES output lanes.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        begin a new message (honoured only in IDLE)
//   din_valid    input lane beat valid
//   din_last     final beat of the message (qualified by din_valid)
//   din_ready    controller accepts a beat this cycle
//   absorb_en    datapath XORs the input lane into lane lane_idx
//   lane_idx     current lane for absorb and squeeze
//   round_en     datapath applies one round this cycle
//   round_idx    current round number
//   round_const  iota constant for round_idx
//   last_round   round_en on the final round
//   dout_valid   lane lane_idx is on the datapath output
//   dout_ready   consumer accepts the output lane
//   done         pulse on the accept of the final output lane
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4,
    parameter int LANE_W     = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    output logic              absorb_en,
    output logic [LANE_W-1:0] lane_idx,
    output logic              round_en,
    output logic [4:0]        round_idx,
    output logic [63:0]       round_const,
    output logic              last_round,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        PERMUTE = 2'd2,
        SQUEEZE = 2'd3
    } state_t;

    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(RATE_LANES - 1);
    localparam logic [LANE_W-1:0] OUT_LAST   = LANE_W'(OUT_LANES - 1);
    localparam logic [4:0]        ROUND_LAST = 5'(NUM_ROUNDS - 1);
    localparam logic [7:0]        LFSR_SEED  = 8'h01;

    state_t            state_r, state_s;
    logic [LANE_W-1:0] lane_r, lane_s;
    logic [4:0]        round_r, round_s;
    logic [7:0]        lfsr_r, lfsr_s;
    logic              final_r, final_s;

    // One Galois step of x^8+x^6+x^5+x^4+1; the output bit is lfsr[0] before the step.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
    endfunction

    // Seven steps make one round's worth of constant bits.
    function automatic logic [7:0] lfsr_adv7(input logic [7:0] seed);
        logic [7:0] r;
        r = seed;
        for (int i = 0; i < 7; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    // Step j's output bit lands at bit position 2^j-1 of the iota constant.
    function automatic logic [63:0] rc_expand(input logic [7:0] seed);
        logic [7:0]  r;
        logic [63:0] rc;
        rc     = 64'd0;
        r      = seed;
        rc[0]  = r[0];
        r      = lfsr_step(r);
        rc[1]  = r[0];
        r      = lfsr_step(r);
        rc[3]  = r[0];
        r      = lfsr_step(r);
        rc[7]  = r[0];
        r      = lfsr_step(r);
        rc[15] = r[0];
        r      = lfsr_step(r);
        rc[31] = r[0];
        r      = lfsr_step(r);
        rc[63] = r[0];
        return rc;
    endfunction

    assign lane_idx    = lane_r;
    assign round_idx   = round_r;
    assign round_const = rc_expand(lfsr_r);

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        state_s    = state_r;
        lane_s     = lane_r;
        round_s    = round_r;
        lfsr_s     = lfsr_r;
        final_s    = final_r;
        din_ready  = 1'b0;
        absorb_en  = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;
        dout_valid = 1'b0;
        done       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ABSORB;
                    lane_s  = {LANE_W{1'b0}};
                    final_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            ABSORB: begin
                din_ready = 1'b1;
                absorb_en = din_valid;
                if (din_valid) begin
                    if ((lane_r == LANE_LAST) || din_last) begin
                        // Short final block: remaining lanes are padded upstream.
                        state_s = PERMUTE;
                        lane_s  = {LANE_W{1'b0}};
                        round_s = 5'd0;
                        lfsr_s  = LFSR_SEED;
                        final_s = din_last;
                    end else begin
                        lane_s = lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ABSORB;
                end
            end
            PERMUTE: begin
                round_en = 1'b1;
                lfsr_s   = lfsr_adv7(lfsr_r);
                if (round_r == ROUND_LAST) begin
                    last_round = 1'b1;
                    state_s    = final_r ? SQUEEZE : ABSORB;
                    round_s    = 5'd0;
                    lane_s     = {LANE_W{1'b0}};
                end else begin
                    round_s = round_r + 5'd1;
                end
            end
            SQUEEZE: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    if (lane_r == OUT_LAST) begin
                        done    = 1'b1;
                        state_s = IDLE;
                        lane_s  = {LANE_W{1'b0}};
                    end else begin
                        lane_s = lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = SQUEEZE;
                end
            end
            default: begin
                state_s = IDLE;
                lane_s  = {LANE_W{1'b0}};
                round_s = 5'd0;
                lfsr_s  = LFSR_SEED;
                final_s = 1'b0;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            lane_r  <= {LANE_W{1'b0}};
            round_r <= 5'd0;
            lfsr_r  <= LFSR_SEED;
            final_r <= 1'b0;
        end else begin
            state_r <= state_s;
            lane_r  <= lane_s;
            round_r <= round_s;
            lfsr_r  <= lfsr_s;
            final_r <= final_s;
        end
    end

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

Sequencing controller for the lane-serial Keccak core. It accepts rate lanes one 64-bit beat at a time, runs the permutation for `NUM_ROUNDS` rounds, and emits the matching iota round constant on each round. It then streams the output lanes. It drives the absorb, round and squeeze enables of the datapath, and it owns the lane and round counters that the datapath indexes with.

## Interface
- `NUM_ROUNDS`, default 24: permutation rounds per block. Legal range 1..24.
- `RATE_LANES`, default 17: lanes absorbed per block. Legal range 1..25.
- `OUT_LANES`, default 4: lanes squeezed after the final block. Legal range 1..`RATE_LANES`.
- `LANE_W`, default `(RATE_LANES > 1) ? $clog2(RATE_LANES) : 1`: lane index width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a new message; sampled only in IDLE.
- `din_valid`  in  1  input lane beat valid.
- `din_last`  in  1  beat is the final beat of the message; qualified by `din_valid`.
- `din_ready`  out  1  controller accepts a beat this cycle.
- `absorb_en`  out  1  datapath XORs the input lane into lane `lane_idx`.
- `lane_idx`  out  LANE_W  current lane for absorb and squeeze.
- `round_en`  out  1  datapath applies one round this cycle.
- `round_idx`  out  5  current round number.
- `round_const`  out  64  iota constant for `round_idx`.
- `last_round`  out  1  `round_en` and `round_idx == NUM_ROUNDS-1`.
- `dout_valid`  out  1  lane `lane_idx` is presented on the datapath output.
- `dout_ready`  in  1  consumer accepts the output lane.
- `done`  out  1  one-cycle pulse when the final output lane is accepted.

## Operation
- The FSM has four states: IDLE, ABSORB, PERMUTE, SQUEEZE.
- Reset value: state IDLE. Every output is 0, except `round_const`, which is 0x0000000000000001 (the round-0 constant). The internal `final_blk` flag and the LFSR are reset; the LFSR reset value is 0x01.
- IDLE:
  - `start` = 1 moves to ABSORB with `lane_idx` = 0 and `final_blk` = 0.
  - `din_valid` is ignored.
- ABSORB:
  - `din_ready` = 1.
  - Accept means `din_valid && din_ready`. `absorb_en` = accept, combinationally.
  - On each accept, `lane_idx` increments.
  - On an accept with `lane_idx == RATE_LANES-1`, or with `din_last` = 1, the FSM moves to PERMUTE. It clears `lane_idx` and `round_idx` and reloads the LFSR to 0x01. It also sets `final_blk` to the value of `din_last` on that beat.
  - When `din_last` is accepted before the lane wraps, the remaining lanes are not absorbed (no `absorb_en`); padding is the upstream block's job.
- PERMUTE:
  - `round_en` = 1 every cycle.
  - `round_idx` runs 0..`NUM_ROUNDS-1`, one round per cycle.
  - The LFSR is x^8+x^6+x^5+x^4+1 in Galois form. It advances 7 steps per round, unrolled combinationally in a single cycle.
  - Bit j of `round_const` (j = 0..6) is the LFSR output bit of step j, placed at bit position 2^j−1. All other bits of `round_const` are 0.
  - On `last_round`, the FSM moves to SQUEEZE if `final_blk` = 1, otherwise back to ABSORB, with `lane_idx` = 0.
- SQUEEZE:
  - `dout_valid` = 1.
  - `lane_idx` increments when `dout_ready` = 1.
  - On an accept with `lane_idx == OUT_LANES-1`, `done` pulses and the FSM moves to IDLE.
  - The FSM holds while `dout_ready` = 0.
- Counter wrap: `lane_idx` never exceeds `RATE_LANES-1` and `round_idx` never exceeds `NUM_ROUNDS-1`. Both return to 0 on state exit.

## Timing
- Absorb: one lane per cycle at full throughput. `din_ready` does not depend combinationally on `din_valid`.
- The first round is applied in the cycle after the final absorb accept.
- Permutation latency is exactly `NUM_ROUNDS` cycles, with `round_en` asserted continuously.
- Block throughput: `RATE_LANES` + `NUM_ROUNDS` cycles per block with no stalls.
- `dout_valid` rises in the cycle after `last_round`.
- `done` is asserted in the same cycle as the last squeeze accept. It is not registered one cycle later.
- Reset mid-operation: `rst` = 0 on any edge returns the FSM to IDLE with reset values on the next cycle. Reset takes priority over `start`, `din_valid` and `dout_ready`.
- `start` outside IDLE is ignored. `dout_ready` outside SQUEEZE is ignored.

## Test plan
- Reset check: hold `rst` = 0 while driving `start` = 1 and `din_valid` = 1. Required: all outputs 0, `round_const` = 0x1, and no state change.
- Single block, default parameters: 17 beats with `din_last` on beat 17, then 4 squeeze beats. Required:
  - 24 consecutive `round_en` cycles.
  - `round_const` = 0x0000000000000001 at round 0, 0x0000000000008082 at round 1, 0x8000000080008008 at round 23.
  - `done` coincides with the 4th `dout_ready` accept.
- Early last: `din_last` on beat 5. Required: exactly 5 `absorb_en` pulses, then PERMUTE, and `lane_idx` back to 0.
- Multi-block: 34 beats with `din_last` on beat 34. Required: two 24-cycle permutations, with an ABSORB phase in between that restarts at `lane_idx` = 0.
- Backpressure: toggle `din_valid` and `dout_ready` randomly. Required: `lane_idx` advances only on handshakes, and the round sequence is unaffected.
- Mid-permute reset: assert `rst` = 0 at round 10. Required: IDLE on the next cycle. A following `start` runs a clean message from round 0 with `round_const` = 0x1.
